intr_handler_mc: RTL and testbench

- Multi-channel successor of the single-line interrupt/enable handshake FSM in the ITC99 benchmark set.
- Arbitrates NCH request lines (eql[NCH-1:0]) round-robin and runs the enable/interrupt handshake on the granted channel.
- Drives the same cc_mux/uscite/ackout/enable_count outputs as the single-line block.
- Adds two features: a per-transaction timeout and a granted-channel index output.

---
 rtl/intr_handler_mc_pkg.sv | 24 ++
 rtl/intr_handler_mc_rr_arbiter.sv | 28 ++
 rtl/intr_handler_mc.sv | 170 +++++++++++++++++
 tb/tb_intr_handler_mc.sv | 135 +++++++++++++
 4 files changed

// File: rtl/intr_handler_mc_pkg.sv
// Shared types and output codes for the multi-channel interrupt handshake handler.
package intr_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_INTR_1 = 3'd2,
    S_ENIN   = 3'd3,
    S_ENIN_W = 3'd4,
    S_INTR   = 3'd5,
    S_INTR_W = 3'd6,
    S_TOUT   = 3'd7
  } state_e;

  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  localparam logic [1:0] OUT_NORM  = 2'b01;
  localparam logic [1:0] OUT_ACK   = 2'b00;
  localparam logic [1:0] OUT_IDONE = 2'b11;
  localparam logic [1:0] OUT_TOUT  = 2'b10;

endpackage

// File: rtl/intr_handler_mc_rr_arbiter.sv
// Round-robin priority scan: first set request after rr_ptr_i, with wrap-around.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         eql_i,
  input  logic [$clog2(NCH)-1:0] rr_ptr_i,
  output logic [$clog2(NCH)-1:0] grant_o,
  output logic                   any_o
);

  localparam int IW = $clog2(NCH);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;

  // rot[k] is the request (rr_ptr_i + 1 + k) mod NCH
  assign dbl   = {eql_i, eql_i};
  assign rot   = NCH'(dbl >> (int'(rr_ptr_i) + 1));
  assign any_o = |eql_i;

  always_comb begin
    grant_o = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) grant_o = IW'((int'(rr_ptr_i) + 1 + k) % NCH);
    end
  end

endmodule

// File: rtl/intr_handler_mc.sv
// Multi-channel enable/interrupt handshake FSM with round-robin grant and per-transaction timeout.
// state    | meaning
// S_INIT   | post-reset, announce normal status
// S_WAIT   | idle, grant into enable handshake
// S_INTR_1 | idle, grant into interrupt handshake
// S_ENIN   | enable handshake, waiting for req drop
// S_ENIN_W | enable done, waiting for req to stay low
// S_INTR   | interrupt handshake, waiting for req drop
// S_INTR_W | interrupt done, waiting for req to stay low
// S_TOUT   | one-cycle timeout report
module intr_handler_mc
  import intr_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCH-1:0]         eql,
  input  logic                   cont_eql,
  output logic [1:0]             cc_mux,
  output logic [1:0]             uscite,
  output logic                   enable_count,
  output logic                   ackout,
  output logic [$clog2(NCH)-1:0] chan_sel,
  output logic                   timeout
);

  localparam int IW = $clog2(NCH);
  localparam logic [CW-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [1:0]    cc_mux_q, cc_mux_d;
  logic [1:0]    uscite_q, uscite_d;
  logic          enable_count_q, enable_count_d;
  logic          ackout_q, ackout_d;
  logic [IW-1:0] chan_sel_q, chan_sel_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [IW-1:0] grant;
  logic          any;
  logic          req;
  logic          at_limit;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .eql_i    (eql),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant),
    .any_o    (any)
  );

  assign req      = eql[chan_sel_q];
  assign at_limit = (WAIT_MAX != 0) && (wait_cnt_q >= WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_INIT;
      cc_mux_q       <= 2'b00;
      uscite_q       <= 2'b00;
      enable_count_q <= 1'b0;
      ackout_q       <= 1'b0;
      chan_sel_q     <= '0;
      rr_ptr_q       <= IW'(NCH - 1);
      timeout_q      <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cc_mux_q       <= cc_mux_d;
      uscite_q       <= uscite_d;
      enable_count_q <= enable_count_d;
      ackout_q       <= ackout_d;
      chan_sel_q     <= chan_sel_d;
      rr_ptr_q       <= rr_ptr_d;
      timeout_q      <= timeout_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_WAIT;
      S_WAIT:   state_d = any ? S_ENIN : S_INTR_1;
      S_INTR_1: state_d = any ? S_INTR : S_WAIT;
      S_ENIN:   state_d = !req ? S_ENIN_W : (at_limit ? S_TOUT : S_ENIN);
      S_ENIN_W: state_d = req ? S_ENIN_W : S_WAIT;
      S_INTR:   state_d = !req ? S_INTR_W : (at_limit ? S_TOUT : S_INTR);
      S_INTR_W: state_d = req ? S_INTR_W : S_WAIT;
      S_TOUT:   state_d = S_WAIT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    cc_mux_d       = cc_mux_q;
    uscite_d       = uscite_q;
    ackout_d       = ~cont_eql;
    enable_count_d = ~cont_eql;
    timeout_d      = 1'b0;
    chan_sel_d     = chan_sel_q;
    rr_ptr_d       = rr_ptr_q;
    wait_cnt_d     = wait_cnt_q;
    case (state_q)
      S_INIT: begin
        cc_mux_d = CC_ENIN;
        uscite_d = OUT_NORM;
      end
      S_WAIT, S_INTR_1: begin
        if (any) begin
          chan_sel_d = grant;
          uscite_d   = OUT_ACK;
          cc_mux_d   = CC_ACKIN;
          wait_cnt_d = '0;
        end else begin
          uscite_d = OUT_NORM;
          cc_mux_d = (state_q == S_WAIT) ? CC_INTR : CC_ENIN;
        end
      end
      S_ENIN, S_INTR: begin
        if (req) begin
          // Outputs hold through the cycle that leaves for S_TOUT; the counter saturates.
          uscite_d = OUT_ACK;
          cc_mux_d = CC_ACKIN;
          if (!at_limit && !(&wait_cnt_q)) wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (state_q == S_ENIN) begin
          uscite_d       = OUT_NORM;
          cc_mux_d       = CC_ENIN;
          ackout_d       = 1'b1;
          enable_count_d = 1'b1;
        end else begin
          uscite_d = OUT_IDONE;
          cc_mux_d = CC_INTR;
        end
      end
      S_ENIN_W: begin
        uscite_d = OUT_NORM;
        cc_mux_d = CC_ENIN;
        if (!req) rr_ptr_d = chan_sel_q;
      end
      S_INTR_W: begin
        if (req) begin
          uscite_d = OUT_IDONE;
          cc_mux_d = CC_INTR;
        end else begin
          uscite_d = OUT_NORM;
          cc_mux_d = CC_ENIN;
          rr_ptr_d = chan_sel_q;
        end
      end
      S_TOUT: begin
        timeout_d = 1'b1;
        uscite_d  = OUT_TOUT;
        cc_mux_d  = CC_ENIN;
        rr_ptr_d  = chan_sel_q;
      end
      default: ;
    endcase
  end

  assign cc_mux       = cc_mux_q;
  assign uscite       = uscite_q;
  assign enable_count = enable_count_q;
  assign ackout       = ackout_q;
  assign chan_sel     = chan_sel_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_intr_handler_mc.sv
// Directed bench for intr_handler_mc: vector table for the handshakes, hand sequences for timeout and reset.
module tb_intr_handler_mc;

  logic       clock;
  logic       reset;
  logic [3:0] eql;
  logic       cont_eql;
  logic [1:0] cc_mux;
  logic [1:0] uscite;
  logic       enable_count;
  logic       ackout;
  logic [1:0] chan_sel;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] eql;
    logic       ce;
    logic [1:0] cc;
    logic [1:0] us;
    logic       ack;
    logic       en;
    logic [1:0] ch;
    logic       to;
  } vec_t;

  vec_t vecs [22];

  intr_handler_mc #(.NCH(4), .WAIT_MAX(15), .CW(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .enable_count (enable_count),
    .ackout       (ackout),
    .chan_sel     (chan_sel),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic r, input logic [3:0] e, input logic c);
    @(negedge clock);
    reset    = r;
    eql      = e;
    cont_eql = c;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] cc, input logic [1:0] us,
                       input logic ack, input logic en, input logic [1:0] ch, input logic to);
    logic [8:0] act, exp;
    act = {cc_mux, uscite, ackout, enable_count, chan_sel, timeout};
    exp = {cc, us, ack, en, ch, to};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cc=%b us=%b ack=%b en=%b ch=%0d to=%b, want cc=%b us=%b ack=%b en=%b ch=%0d to=%b",
               name, cc_mux, uscite, ackout, enable_count, chan_sel, timeout, cc, us, ack, en, ch, to);
    end
  endtask

  initial begin
    reset    = 1'b1;
    eql      = 4'b0000;
    cont_eql = 1'b1;

    // rst, eql, cont_eql | cc, uscite, ackout, enable_count, chan_sel, timeout
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 4'b0100, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[11] = '{1'b0, 4'b1001, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[12] = '{1'b0, 4'b1001, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[13] = '{1'b0, 4'b0001, 1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 4'b1001, 1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[15] = '{1'b0, 4'b0001, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[16] = '{1'b0, 4'b1001, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 4'b1000, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 4'b1000, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[19] = '{1'b0, 4'b1001, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[20] = '{1'b0, 4'b0001, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 2'd3, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 2'd3, 1'b0};

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rst, vecs[i].eql, vecs[i].ce);
      check($sformatf("vec%0d", i), vecs[i].cc, vecs[i].us, vecs[i].ack,
            vecs[i].en, vecs[i].ch, vecs[i].to);
    end

    // Timeout: channel 1 holds its request, 15 cycles in S_ENIN, then S_TOUT.
    step(1'b0, 4'b0010, 1'b1);
    check("tout_grant", 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 4'b0010, 1'b1);
      check($sformatf("tout_hold%0d", i), 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0);
    end
    step(1'b0, 4'b0010, 1'b1);
    check("tout_enter", 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b0, 4'b0011, 1'b1);
    check("tout_pulse", 2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b0, 4'b0011, 1'b1);
    check("tout_skip", 2'b11, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset while waiting in S_ENIN_W with cont_eql low.
    step(1'b0, 4'b0010, 1'b1);
    check("rst_enin_exit", 2'b01, 2'b01, 1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    check("rst_enin_w_hold", 2'b01, 2'b01, 1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    check("rst_mid", 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    check("rst_init", 2'b01, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b1);
    check("rst_ptr", 2'b11, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
